// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI3 types, response codes and the per-beat response rule
package axi_pkg;
    localparam int ID_W = 4;
    localparam int LEN_W = 8;
    typedef enum logic [1:0] {BURST_FIXED = 2'd0, BURST_INCR = 2'd1, BURST_WRAP = 2'd2} burst_t;
    typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;
    typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;
    // Out-of-range beats report DECERR ahead of any size/burst problem
    function automatic resp_t beat_resp(input logic in_range, input logic [2:0] size, input logic [1:0] burst);
        return !in_range ? DECERR : (size > 3'd2 || burst == 2'b11) ? SLVERR : OKAY;
    endfunction
endpackage

// File: rtl/axi_mem_slave_if.sv
// axi_mem_slave_if: AXI3 AR/R/AW/W/B channel bundle with master and slave views
interface axi_mem_slave_if;
    import axi_pkg::*;
    logic [ID_W-1:0]  arid;
    logic [31:0]      araddr;
    logic [LEN_W-1:0] arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic             arvalid;
    logic             arready;
    logic [ID_W-1:0]  rid;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic             rvalid;
    logic             rready;
    logic [ID_W-1:0]  awid;
    logic [31:0]      awaddr;
    logic [LEN_W-1:0] awlen;
    logic [2:0]       awsize;
    logic [1:0]       awburst;
    logic             awvalid;
    logic             awready;
    logic [ID_W-1:0]  wid;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic             wlast;
    logic             wvalid;
    logic             wready;
    logic [ID_W-1:0]  bid;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready;
    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: address of the following beat for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen import axi_pkg::*; (
    input  logic [31:0]      addr,
    input  logic [2:0]       size,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       burst,
    output logic [31:0]      next_addr
);
    logic [31:0] step;
    logic [31:0] wrap_mask;
    logic        wrap_ok;
    // WRAP with an illegal length degrades to INCR; reserved bursts never touch memory so their address is irrelevant
    always_comb begin
        step = 32'd1 << size;
        wrap_ok = burst == BURST_WRAP && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        next_addr = burst == BURST_FIXED ? addr
                  : wrap_ok ? (addr & ~wrap_mask) | ((addr + step) & wrap_mask)
                  : addr + step;
    end
endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: single-outstanding AXI3 responder backed by a word-addressed memory
module axi_mem_slave import axi_pkg::*; #(
    parameter int          MEM_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
    parameter string       INIT_FILE = ""
) (
    input logic clk,
    input logic rst,
    axi_mem_slave_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

    logic [31:0] mem [MEM_WORDS];

    state_t           state;
    grant_t           last_grant;
    logic             rdy;
    logic [ID_W-1:0]  id;
    logic [31:0]      addr;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] beat;
    logic [2:0]       size;
    logic [1:0]       burst;
    resp_t            werr;
    logic [31:0]      next_addr;
    logic             both;
    logic             ar_hs;
    logic             aw_hs;
    logic             r_hs;
    logic             w_hs;
    logic             b_hs;
    logic             w_en;
    logic             bad_last;
    logic [31:0]      pa;
    logic [2:0]       psize;
    logic [1:0]       pburst;
    logic [31:0]      p_off;
    logic [31:0]      w_off;
    logic [31:0]      p_data;
    resp_t            p_resp;
    resp_t            w_beat;
    resp_t            w_acc;
    logic             rvalid_q;
    logic             rlast_q;
    logic [ID_W-1:0]  rid_q;
    resp_t            rresp_q;
    logic [31:0]      rdata_q;
    logic             wready_q;
    logic             bvalid_q;
    logic [ID_W-1:0]  bid_q;
    resp_t            bresp_q;
    logic             unused_wid;

    axi_burst_addr_gen u_addr_gen (
        .addr      (addr),
        .size      (size),
        .len       (len),
        .burst     (burst),
        .next_addr (next_addr)
    );

    assign unused_wid = ^bus.wid;
    assign bus.arready = rdy && !(both && last_grant == GRANT_READ);
    assign bus.awready = rdy && !(both && last_grant == GRANT_WRITE);
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rid     = rid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;

    // Handshakes, the read beat to present next (first beat comes straight off AR) and the write beat's error merge
    always_comb begin
        both = bus.arvalid && bus.awvalid;
        ar_hs = bus.arvalid && bus.arready;
        aw_hs = bus.awvalid && bus.awready;
        r_hs = rvalid_q && bus.rready;
        w_hs = wready_q && bus.wvalid;
        b_hs = bvalid_q && bus.bready;
        pa = state == IDLE ? bus.araddr : next_addr;
        psize = state == IDLE ? bus.arsize : size;
        pburst = state == IDLE ? bus.arburst : burst;
        p_off = pa - BASE_ADDR;
        p_resp = beat_resp(p_off < MEM_BYTES, psize, pburst);
        p_data = p_resp == OKAY ? mem[p_off[AW+1:2]] : 32'd0;
        w_off = addr - BASE_ADDR;
        w_beat = beat_resp(w_off < MEM_BYTES, size, burst);
        bad_last = bus.wlast != (beat == len);
        w_en = w_hs && !rst && w_beat == OKAY;
        w_acc = (werr == DECERR || w_beat == DECERR) ? DECERR
              : (werr == SLVERR || w_beat == SLVERR || bad_last) ? SLVERR : OKAY;
    end

    // Transaction FSM: alternating arbitration, read beat streaming, write beat counting and the B response
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= GRANT_WRITE;
            rdy <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q <= 1'b0;
            rid_q <= '0;
            rresp_q <= OKAY;
            rdata_q <= '0;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            bid_q <= '0;
            bresp_q <= OKAY;
        end else begin
            case (state)
                IDLE: begin
                    rdy <= !(ar_hs || aw_hs);
                    if (ar_hs) begin
                        state <= RD;
                        last_grant <= GRANT_READ;
                        id <= bus.arid;
                        addr <= bus.araddr;
                        len <= bus.arlen;
                        size <= bus.arsize;
                        burst <= bus.arburst;
                        beat <= '0;
                        rvalid_q <= 1'b1;
                        rid_q <= bus.arid;
                        rdata_q <= p_data;
                        rresp_q <= p_resp;
                        rlast_q <= bus.arlen == 8'd0;
                    end else if (aw_hs) begin
                        state <= WR;
                        last_grant <= GRANT_WRITE;
                        id <= bus.awid;
                        addr <= bus.awaddr;
                        len <= bus.awlen;
                        size <= bus.awsize;
                        burst <= bus.awburst;
                        beat <= '0;
                        werr <= OKAY;
                        wready_q <= 1'b1;
                    end
                end
                RD: if (r_hs) begin
                    if (beat == len) begin
                        state <= IDLE;
                        rdy <= 1'b1;
                        rvalid_q <= 1'b0;
                        rlast_q <= 1'b0;
                    end else begin
                        addr <= next_addr;
                        beat <= beat + 8'd1;
                        rdata_q <= p_data;
                        rresp_q <= p_resp;
                        rlast_q <= beat + 8'd1 == len;
                    end
                end
                WR: if (w_hs) begin
                    werr <= w_acc;
                    addr <= next_addr;
                    if (beat == len) begin
                        state <= WRESP;
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        bid_q <= id;
                        bresp_q <= w_acc;
                    end else begin
                        beat <= beat + 8'd1;
                    end
                end
                WRESP: if (b_hs) begin
                    state <= IDLE;
                    rdy <= 1'b1;
                    bvalid_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte-strobed memory write in the W handshake cycle; contents survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (w_en && bus.wstrb[i]) mem[w_off[AW+1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed AXI3 traffic checked against a transaction-level memory model
module tb_axi_mem_slave;
    localparam logic [31:0] BASE = 32'h1C00_0000;
    localparam int MW = 16384;

    typedef struct packed {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
        logic [31:0] data;
    } rbeat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_mem_slave_if bus();

    axi_mem_slave #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .INIT_FILE("")) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    rbeat_t rexp[$];
    logic [5:0] bexp[$];
    logic [31:0] mdl [int];
    logic [31:0] wd [16];
    logic [3:0] ws [16];
    logic [31:0] rd_got[$];
    logic [1:0] rr_got[$];
    logic rl_got[$];
    int first_cyc;
    logic [3:0] b_id;
    logic [1:0] b_resp;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst, input int i);
        longint s = longint'(1) << size;
        longint n = longint'(len) + 1;
        longint la = longint'(a);
        longint blen;
        longint base;
        if (burst == 2'd0) return a;
        if (burst == 2'd2 && (n == 2 || n == 4 || n == 8 || n == 16)) begin
            blen = n * s;
            base = (la / blen) * blen;
            return 32'(base + ((la - base) + longint'(i) * s) % blen);
        end
        return 32'(la + longint'(i) * s);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
        if (a < BASE || a >= BASE + 32'(4 * MW)) return 2'b11;
        if (size > 3'd2 || burst == 2'd3) return 2'b10;
        return 2'b00;
    endfunction

    task automatic mdl_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] ba = beat_addr(a, size, len, burst, i);
            logic [1:0] r = exp_resp(ba, size, burst);
            rexp.push_back({id, r, i == int'(len), r == 2'b00 ? mdl[int'(ba >> 2)] : 32'd0});
        end
    endtask

    task automatic mdl_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input bit bad_last);
        logic [1:0] err = 2'b00;
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] ba = beat_addr(a, size, len, burst, i);
            logic [1:0] r = exp_resp(ba, size, burst);
            bit mism = bad_last && i == int'(len);
            if (r == 2'b00) begin
                int k = int'(ba >> 2);
                logic [31:0] w = mdl.exists(k) ? mdl[k] : 32'd0;
                for (int b = 0; b < 4; b++) if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
                mdl[k] = w;
            end
            if (r == 2'b11) err = 2'b11;
            else if (err != 2'b11 && (r == 2'b10 || mism)) err = 2'b10;
        end
        bexp.push_back({id, err});
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        bus.arid = id; bus.araddr = a; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        bus.awid = id; bus.awaddr = a; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bit ok = 0;
        set_ar(id, a, len, size, burst);
        bus.arvalid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk); ok = bus.arready;
            @(posedge clk); #1; n++;
        end
        bus.arvalid = 1'b0;
        chk("ar_handshake", 64'(ok), 64'd1);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bit ok = 0;
        set_aw(id, a, len, size, burst);
        bus.awvalid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk); ok = bus.awready;
            @(posedge clk); #1; n++;
        end
        bus.awvalid = 1'b0;
        chk("aw_handshake", 64'(ok), 64'd1);
    endtask

    task automatic send_w(input logic [7:0] len, input bit bad_last);
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            bit ok = 0;
            bus.wdata = wd[i]; bus.wstrb = ws[i];
            bus.wlast = i == int'(len) && !bad_last;
            bus.wvalid = 1'b1;
            while (!ok && n < 50) begin
                @(negedge clk); ok = bus.wready;
                @(posedge clk); #1; n++;
            end
            if (!ok) begin
                chk("w_handshake", 64'(ok), 64'd1);
                break;
            end
        end
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
    endtask

    task automatic get_b();
        int n = 0;
        bit ok = 0;
        bus.bready = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (bus.bvalid) begin ok = 1; b_id = bus.bid; b_resp = bus.bresp; end
            @(posedge clk); #1; n++;
        end
        bus.bready = 1'b0;
        chk("b_handshake", 64'(ok), 64'd1);
    endtask

    task automatic r_collect(input int cnt, input bit toggle);
        int got = 0;
        int cyc = 0;
        bit t = 1;
        rd_got.delete(); rr_got.delete(); rl_got.delete();
        first_cyc = -1;
        while (got < cnt && cyc < 400) begin
            bus.rready = toggle ? t : 1'b1;
            t = ~t;
            @(negedge clk);
            if (bus.rvalid && first_cyc < 0) first_cyc = cyc;
            if (bus.rvalid && bus.rready) begin
                rd_got.push_back(bus.rdata); rr_got.push_back(bus.rresp); rl_got.push_back(bus.rlast);
                got++;
            end
            @(posedge clk); #1; cyc++;
        end
        bus.rready = 1'b0;
        chk("r_beats_received", 64'(got), 64'(cnt));
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input bit toggle);
        mdl_read(id, a, len, 3'd2, burst);
        send_ar(id, a, len, 3'd2, burst);
        r_collect(int'(len) + 1, toggle);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input bit bad_last);
        mdl_write(id, a, len, 3'd2, 2'd1, bad_last);
        send_aw(id, a, len, 3'd2, 2'd1);
        send_w(len, bad_last);
        get_b();
    endtask

    task automatic post_reset_checks();
        @(negedge clk);
        chk("reset_ctrl", 64'({bus.rvalid, bus.bvalid, bus.wready, bus.arready, bus.awready, bus.rlast}), 64'd0);
        chk("reset_payload", 64'({bus.rid, bus.bid, bus.rresp, bus.bresp, bus.rdata}), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_ready", 64'({bus.arready, bus.awready}), 64'b11);
        @(posedge clk); #1;
    endtask

    // Scoreboard: every cycle an R or B beat is offered, it must be the model's oldest outstanding one
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rvalid) begin
                if (rexp.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL r_unexpected: rvalid=1 rdata=%h with no beat outstanding", bus.rdata);
                end else begin
                    chk("r_beat", 64'({bus.rid, bus.rresp, bus.rlast, bus.rdata}), 64'(rexp[0]));
                    if (bus.rready) void'(rexp.pop_front());
                end
            end
            if (bus.bvalid) begin
                if (bexp.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b_unexpected: bvalid=1 bid=%h with no response outstanding", bus.bid);
                end else begin
                    chk("b_resp", 64'({bus.bid, bus.bresp}), 64'(bexp[0]));
                    if (bus.bready) void'(bexp.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0; bus.rready = 0; bus.bready = 0;
        bus.wid = 4'd0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
        set_ar(4'd0, 32'd0, 8'd0, 3'd2, 2'd1);
        set_aw(4'd0, 32'd0, 8'd0, 3'd2, 2'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        post_reset_checks();

        // Simultaneous AR/AW: read wins first (reset grant was write); the read is out of range
        mdl_read(4'd8, BASE + 32'(4 * MW), 8'd0, 3'd2, 2'd1);
        set_ar(4'd8, BASE + 32'(4 * MW), 8'd0, 3'd2, 2'd1);
        set_aw(4'd9, BASE + 32'h300, 8'd0, 3'd2, 2'd1);
        bus.arvalid = 1; bus.awvalid = 1;
        @(negedge clk);
        chk("both1_ready", 64'({bus.arready, bus.awready}), 64'b10);
        @(posedge clk); #1;
        bus.arvalid = 0; bus.awvalid = 0;
        r_collect(1, 0);
        chk("decerr_resp", 64'(rr_got[0]), 64'b11);
        chk("decerr_data", 64'(rd_got[0]), 64'd0);
        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        mdl_write(4'd9, BASE + 32'h300, 8'd0, 3'd2, 2'd1, 0);
        bus.arvalid = 1; bus.awvalid = 1;
        @(negedge clk);
        chk("both2_ready", 64'({bus.arready, bus.awready}), 64'b01);
        @(posedge clk); #1;
        bus.arvalid = 0; bus.awvalid = 0;
        send_w(8'd0, 0);
        get_b();
        chk("both2_bid", 64'(b_id), 64'h9);

        // Single-beat read of a preloaded word
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        do_write(4'd1, BASE, 8'd0, 0);
        do_read(4'd3, BASE, 8'd0, 2'd1, 0);
        chk("single_data", 64'(rd_got[0]), 64'hDEAD_BEEF);
        chk("single_resp_last", 64'({rr_got[0], rl_got[0]}), 64'b001);
        chk("single_latency", 64'(first_cyc), 64'd0);

        // 16-beat INCR read with rready toggling
        for (int i = 0; i < 16; i++) begin wd[i] = 32'hC0DE_0000 + 32'(i); ws[i] = 4'hF; end
        do_write(4'd2, BASE + 32'h100, 8'd15, 0);
        do_read(4'd4, BASE + 32'h100, 8'd15, 2'd1, 1);
        for (int i = 0; i < 16 && i < rd_got.size(); i++) begin
            chk("incr16_data", 64'(rd_got[i]), 64'(32'hC0DE_0000 + 32'(i)));
            chk("incr16_last", 64'(rl_got[i]), 64'(i == 15));
        end

        // Strobed write merging
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hAAAA_AAAA; ws[i] = 4'hF; end
        do_write(4'd6, BASE + 32'h200, 8'd3, 0);
        wd[0] = 32'h1122_3344; ws[0] = 4'b1111;
        wd[1] = 32'h5566_7788; ws[1] = 4'b0011;
        wd[2] = 32'h99AA_BBCC; ws[2] = 4'b1100;
        wd[3] = 32'hDDEE_FF00; ws[3] = 4'b0001;
        do_write(4'd5, BASE + 32'h200, 8'd3, 0);
        chk("strobe_b", 64'({b_id, b_resp}), 64'({4'h5, 2'b00}));
        do_read(4'd7, BASE + 32'h200, 8'd3, 2'd1, 0);
        chk("strobe_w0", 64'(rd_got[0]), 64'h1122_3344);
        chk("strobe_w1", 64'(rd_got[1]), 64'hAAAA_7788);
        chk("strobe_w2", 64'(rd_got[2]), 64'h99AA_AAAA);
        chk("strobe_w3", 64'(rd_got[3]), 64'hAAAA_AA00);

        // wlast deasserted on the final beat
        wd[0] = 32'h0; wd[1] = 32'h1; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'd3, BASE + 32'h310, 8'd1, 1);
        chk("bad_wlast_bresp", 64'(b_resp), 64'b10);

        // WRAP len=3 starting at offset 0x08 of a 16-byte window
        do_read(4'd10, BASE + 32'h108, 8'd3, 2'd2, 0);
        chk("wrap_b0", 64'(rd_got[0]), 64'hC0DE_0002);
        chk("wrap_b1", 64'(rd_got[1]), 64'hC0DE_0003);
        chk("wrap_b2", 64'(rd_got[2]), 64'hC0DE_0000);
        chk("wrap_b3", 64'(rd_got[3]), 64'hC0DE_0001);

        // Reset in the middle of an 8-beat read, then a clean read
        mdl_read(4'd11, BASE + 32'h100, 8'd7, 3'd2, 2'd1);
        send_ar(4'd11, BASE + 32'h100, 8'd7, 3'd2, 2'd1);
        r_collect(3, 0);
        rst = 1'b1;
        rexp.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        post_reset_checks();
        do_read(4'd12, BASE, 8'd0, 2'd1, 0);
        chk("after_reset_data", 64'(rd_got[0]), 64'hDEAD_BEEF);

        repeat (2) @(posedge clk);
        chk("r_drained", 64'(rexp.size()), 64'd0);
        chk("b_drained", 64'(bexp.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
